// File: rtl/seq_bin_to_bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// controller state encoding, BCD digit width and counter sizing helper.
package seq_bin_to_bcd_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int BCD_W = 4;

    // Bit-counter width able to hold the values 0..width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3
    import seq_bin_to_bcd_pkg::*;
(
    input  logic [BCD_W-1:0] digit_in,
    output logic [BCD_W-1:0] digit_out
);

    // Conditional +3 correction.
    always_comb begin
        digit_out = (digit_in >= BCD_W'(5)) ? (digit_in + BCD_W'(3)) : digit_in;
    end

endmodule

// File: rtl/seq_bin_to_bcd.sv
// Sequential signed-binary to packed-BCD converter. One magnitude bit is
// shifted into the BCD scratch register per cycle (shift-add-3), so a
// conversion takes WIDTH steps after the accepting edge. bcd/sign are
// holding registers updated only when a conversion completes.
module seq_bin_to_bcd
    import seq_bin_to_bcd_pkg::*;
#(
    parameter int WIDTH  = 17,
    parameter int DIGITS = 5
) (
    input  logic                    clk_50,
    input  logic                    Reset,
    input  logic                    start,
    input  logic [WIDTH-1:0]        data_in,
    output logic                    busy,
    output logic                    done,
    output logic                    sign,
    output logic [BCD_W*DIGITS-1:0] bcd
);

    localparam int CNT_W  = cnt_width(WIDTH);
    localparam int SCR_W  = BCD_W * DIGITS;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mag_q, mag_d;
    logic [SCR_W-1:0]   scratch_q, scratch_d;
    logic               sign_lat_q, sign_lat_d;
    logic [SCR_W-1:0]   bcd_q, bcd_d;
    logic               sign_q, sign_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic [SCR_W-1:0]   scratch_adj;
    logic [SCR_W-1:0]   scratch_next;

    // One correction cell per scratch digit.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_in  (scratch_q[g*BCD_W +: BCD_W]),
            .digit_out (scratch_adj[g*BCD_W +: BCD_W])
        );
    end

    // Corrected scratch shifted left, taking in the next magnitude MSB.
    always_comb begin
        scratch_next = {scratch_adj[SCR_W-2:0], mag_q[WIDTH-1]};
    end

    // Next-state and datapath control.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        cnt_d      = cnt_q;
        mag_d      = mag_q;
        scratch_d  = scratch_q;
        sign_lat_d = sign_lat_q;
        bcd_d      = bcd_q;
        sign_d     = sign_q;
        done_d     = 1'b0;
        busy_d     = busy_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    // Two's-complement negate gives 2^(WIDTH-1) for the most
                    // negative input, which still fits as an unsigned value.
                    sign_lat_d = ~data_in[WIDTH-1];
                    mag_d      = data_in[WIDTH-1] ? (~data_in + WIDTH'(1)) : data_in;
                    scratch_d  = '0;
                    cnt_d      = '0;
                    state_d    = SHIFT;
                    busy_d     = 1'b1;
                end
            end
            SHIFT: begin
                scratch_d = scratch_next;
                mag_d     = {mag_q[WIDTH-2:0], 1'b0};
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // Last step: publish the result including this shift.
                    bcd_d   = scratch_next;
                    sign_d  = sign_lat_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_50) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mag_q      <= '0;
            scratch_q  <= '0;
            sign_lat_q <= 1'b1;
            bcd_q      <= '0;
            sign_q     <= 1'b1;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mag_q      <= mag_d;
            scratch_q  <= scratch_d;
            sign_lat_q <= sign_lat_d;
            bcd_q      <= bcd_d;
            sign_q     <= sign_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sign = sign_q;
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// Self-checking bench for seq_bin_to_bcd: directed vector table, hand-written
// multi-cycle corner cases and a randomized regression against a decimal
// digit-extraction reference model.
module tb_seq_bin_to_bcd;

    localparam int WIDTH  = 17;
    localparam int DIGITS = 5;
    localparam int BW     = 4 * DIGITS;

    logic              clk_50 = 1'b0;
    logic              Reset;
    logic              start;
    logic [WIDTH-1:0]  data_in;
    logic              busy;
    logic              done;
    logic              sign;
    logic [BW-1:0]     bcd;

    int checks = 0;
    int errors = 0;

    seq_bin_to_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk_50  (clk_50),
        .Reset   (Reset),
        .start   (start),
        .data_in (data_in),
        .busy    (busy),
        .done    (done),
        .sign    (sign),
        .bcd     (bcd)
    );

    always #10 clk_50 = ~clk_50;

    typedef struct {
        int            din;
        logic [BW-1:0] exp_bcd;
        logic          exp_sign;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: decimal digits of |v| by repeated division.
    function automatic logic [BW-1:0] model_bcd(input int v);
        int            mag;
        logic [BW-1:0] r;
        mag = (v < 0) ? -v : v;
        r   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(mag % 10);
            mag         = mag / 10;
        end
        return r;
    endfunction

    function automatic logic model_sign(input int v);
        return (v >= 0) ? 1'b1 : 1'b0;
    endfunction

    // Present a one-cycle start at the current negedge; returns one negedge later.
    task automatic pulse_start_now(input int v);
        start   = 1'b1;
        data_in = WIDTH'(v);
        @(negedge clk_50);
        start   = 1'b0;
        data_in = WIDTH'($urandom);
    endtask

    task automatic start_conv(input int v);
        @(negedge clk_50);
        pulse_start_now(v);
    endtask

    // Called one negedge after the accepting edge (lat=1); bounded wait for done.
    task automatic wait_done(output int lat, output int busy_cnt, output bit got);
        lat      = 1;
        busy_cnt = 0;
        got      = 1'b0;
        while (lat <= 40) begin
            if (busy) busy_cnt++;
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk_50);
            lat++;
        end
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_50);
            if (done) n++;
        end
    endtask

    initial begin
        int            lat;
        int            bcnt;
        bit            got;
        int            ndone;
        logic [BW-1:0] prev_bcd;
        logic          prev_sign;
        logic signed [WIDTH-1:0] rs;
        int            v;

        vecs[0] = '{0,      20'h00000, 1'b1};
        vecs[1] = '{12345,  20'h12345, 1'b1};
        vecs[2] = '{-1,     20'h00001, 1'b0};
        vecs[3] = '{65535,  20'h65535, 1'b1};
        vecs[4] = '{-65536, 20'h65536, 1'b0};
        vecs[5] = '{-65535, 20'h65535, 1'b0};
        vecs[6] = '{9,      20'h00009, 1'b1};
        vecs[7] = '{10,     20'h00010, 1'b1};
        vecs[8] = '{-99,    20'h00099, 1'b0};
        vecs[9] = '{40960,  20'h40960, 1'b1};

        Reset   = 1'b0;
        start   = 1'b0;
        data_in = '0;
        repeat (3) @(negedge clk_50);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sign", 32'(sign), 32'd1);
        check("reset_bcd",  32'(bcd),  32'd0);
        Reset = 1'b1;

        // Directed vectors with latency, busy length, hold and pulse checks.
        prev_bcd  = '0;
        prev_sign = 1'b1;
        for (int i = 0; i < 10; i++) begin
            start_conv(vecs[i].din);
            check("hold_bcd",  32'(bcd),  32'(prev_bcd));
            check("hold_sign", 32'(sign), 32'(prev_sign));
            wait_done(lat, bcnt, got);
            check("vec_done_seen", 32'(got),  32'd1);
            check("vec_latency",   32'(lat),  32'd18);
            check("vec_busy_len",  32'(bcnt), 32'd17);
            check("vec_bcd",       32'(bcd),  32'(vecs[i].exp_bcd));
            check("vec_sign",      32'(sign), 32'(vecs[i].exp_sign));
            @(negedge clk_50);
            check("vec_done_pulse", 32'(done), 32'd0);
            prev_bcd  = vecs[i].exp_bcd;
            prev_sign = vecs[i].exp_sign;
        end

        // Start while busy is ignored.
        start_conv(9876);
        repeat (4) @(negedge clk_50);
        pulse_start_now(1);
        wait_done(lat, bcnt, got);
        check("ign_done_seen", 32'(got),  32'd1);
        check("ign_latency",   32'(lat),  32'd13);
        check("ign_bcd",       32'(bcd),  32'h09876);
        check("ign_sign",      32'(sign), 32'd1);
        count_done(30, ndone);
        check("ign_no_extra_done", 32'(ndone), 32'd0);
        check("ign_bcd_held",      32'(bcd),   32'h09876);

        // Back-to-back: start presented in the done cycle.
        start_conv(5);
        wait_done(lat, bcnt, got);
        check("b2b_first_done", 32'(got), 32'd1);
        check("b2b_first_bcd",  32'(bcd), 32'h00005);
        pulse_start_now(-42);
        wait_done(lat, bcnt, got);
        check("b2b_done_seen", 32'(got),  32'd1);
        check("b2b_latency",   32'(lat),  32'd18);
        check("b2b_bcd",       32'(bcd),  32'h00042);
        check("b2b_sign",      32'(sign), 32'd0);

        // Reset in the middle of a conversion.
        start_conv(321);
        wait_done(lat, bcnt, got);
        check("rst_pre_done", 32'(got), 32'd1);
        check("rst_pre_bcd",  32'(bcd), 32'h00321);
        start_conv(500);
        repeat (7) @(negedge clk_50);
        Reset = 1'b0;
        @(negedge clk_50);
        Reset = 1'b1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd",  32'(bcd),  32'd0);
        check("rst_sign", 32'(sign), 32'd1);
        count_done(30, ndone);
        check("rst_no_done", 32'(ndone), 32'd0);
        start_conv(7);
        wait_done(lat, bcnt, got);
        check("rst_next_done", 32'(got),  32'd1);
        check("rst_next_bcd",  32'(bcd),  32'h00007);
        check("rst_next_sign", 32'(sign), 32'd1);

        // Randomized regression against the reference model.
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk_50);
            rs = WIDTH'($urandom);
            v  = int'(rs);
            start_conv(v);
            wait_done(lat, bcnt, got);
            check("rnd_done_seen", 32'(got),  32'd1);
            check("rnd_bcd",       32'(bcd),  32'(model_bcd(v)));
            check("rnd_sign",      32'(sign), 32'(model_sign(v)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
